// File: rtl/antirrebote_teclado_pkg.sv
// Shared constants for the keyboard debouncer and its register stage:
// PicoBlaze port map, debounce defaults and the per-button FSM encoding.
package antirrebote_teclado_pkg;

  localparam int CNT_MAX_DEF = 500000;
  localparam int CNT_W_DEF   = 19;
  localparam int N_BOTONES   = 4;

  localparam logic [7:0] PORT_AUMENTA   = 8'h03;
  localparam logic [7:0] PORT_DISMINUYE = 8'h04;
  localparam logic [7:0] PORT_SIGUIENTE = 8'h05;
  localparam logic [7:0] PORT_ANTERIOR  = 8'h06;

  typedef enum logic [1:0] {
    REPOSO          = 2'd0,
    CONFIRMA_PULSO  = 2'd1,
    PULSADO         = 2'd2,
    CONFIRMA_SUELTA = 2'd3
  } estado_t;

  // Bit order matches the flag vector: {anterior, siguiente, disminuye, aumenta}.
  function automatic logic [3:0] decode_lectura(input logic [7:0] port_id,
                                                input logic       read_strobe);
    logic [3:0] limpia;
    limpia    = 4'b0000;
    limpia[0] = read_strobe && (port_id == PORT_AUMENTA);
    limpia[1] = read_strobe && (port_id == PORT_DISMINUYE);
    limpia[2] = read_strobe && (port_id == PORT_SIGUIENTE);
    limpia[3] = read_strobe && (port_id == PORT_ANTERIOR);
    return limpia;
  endfunction

endpackage

// File: rtl/antirrebote_teclado_if.sv
// PicoBlaze input-port view of the keyboard: address/strobe from the CPU,
// press-pending flags back to it.
interface antirrebote_teclado_if;

  logic [7:0] Port_ID;
  logic       Read_Strobe;
  logic       aumenta;
  logic       disminuye;
  logic       siguiente;
  logic       anterior;

  modport master (
    output Port_ID, Read_Strobe,
    input  aumenta, disminuye, siguiente, anterior
  );

  modport slave (
    input  Port_ID, Read_Strobe,
    output aumenta, disminuye, siguiente, anterior
  );

endinterface

// File: rtl/antirrebote_boton.sv
// One push-button: 2-flop synchronizer, press/release confirmation FSM and
// stable-cycle counter. Emits a single-cycle event per accepted press.
module antirrebote_boton
  import antirrebote_teclado_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulso
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX - 1);

  logic [1:0]       sync;
  logic             entrada;
  estado_t          estado;
  logic [CNT_W-1:0] cnt;

  assign entrada = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b00;
    else        sync <= {sync[0], btn};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado <= REPOSO;
      cnt    <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (entrada) begin
            estado <= CONFIRMA_PULSO;
            cnt    <= '0;
          end
        end
        CONFIRMA_PULSO: begin
          if (!entrada) begin
            estado <= REPOSO;
            cnt    <= '0;
          end else if (cnt == CNT_TOP) begin
            estado <= PULSADO;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PULSADO: begin
          if (!entrada) begin
            estado <= CONFIRMA_SUELTA;
            cnt    <= '0;
          end
        end
        CONFIRMA_SUELTA: begin
          if (entrada) begin
            estado <= PULSADO;
            cnt    <= '0;
          end else if (cnt == CNT_TOP) begin
            estado <= REPOSO;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          estado <= REPOSO;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Decoded from registers only; asserted in the cycle the FSM commits to
  // PULSADO so the flag stage sets on that same edge.
  assign pulso = (estado == CONFIRMA_PULSO) && entrada && (cnt == CNT_TOP);

endmodule

// File: rtl/antirrebote_teclado.sv
// Four debounced keys with press-pending flags, cleared by a PicoBlaze
// INPUT from the key's port; a new press always beats a same-cycle clear.
module antirrebote_teclado
  import antirrebote_teclado_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_aumenta,
  input  logic                   btn_disminuye,
  input  logic                   btn_siguiente,
  input  logic                   btn_anterior,
  antirrebote_teclado_if.slave   bus
);

  logic [N_BOTONES-1:0] btn_vec;
  logic [N_BOTONES-1:0] pulso;
  logic [N_BOTONES-1:0] limpia;
  logic [N_BOTONES-1:0] flags;

  assign btn_vec = {btn_anterior, btn_siguiente, btn_disminuye, btn_aumenta};

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_boton
    antirrebote_boton #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_boton (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_vec[i]),
      .pulso (pulso[i])
    );
  end

  assign limpia = decode_lectura(bus.Port_ID, bus.Read_Strobe);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags <= '0;
    else        flags <= pulso | (flags & ~limpia);
  end

  assign bus.aumenta   = flags[0];
  assign bus.disminuye = flags[1];
  assign bus.siguiente = flags[2];
  assign bus.anterior  = flags[3];

endmodule

// File: tb/tb_antirrebote_teclado.sv
// Directed bench for antirrebote_teclado with CNT_MAX=4: press latency,
// bounce rejection, read-clear decode table, set/clear collision, reset.
module tb_antirrebote_teclado;
  import antirrebote_teclado_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic btn_aumenta, btn_disminuye, btn_siguiente, btn_anterior;
  logic [3:0] fl;

  int n_checks = 0;
  int n_fail   = 0;

  antirrebote_teclado_if bus();

  antirrebote_teclado #(
    .CNT_MAX (4),
    .CNT_W   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_aumenta   (btn_aumenta),
    .btn_disminuye (btn_disminuye),
    .btn_siguiente (btn_siguiente),
    .btn_anterior  (btn_anterior),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  assign fl = {bus.anterior, bus.siguiente, bus.disminuye, bus.aumenta};

  typedef struct {
    logic [7:0] port_id;
    logic       strobe;
    logic [3:0] flags_exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: flags got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: count got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic leer(input logic [7:0] port);
    bus.Port_ID     = port;
    bus.Read_Strobe = 1'b1;
    ciclos(1);
    bus.Read_Strobe = 1'b0;
    bus.Port_ID     = 8'h00;
  endtask

  initial begin
    int subidas;
    int unos;
    logic prev;

    vecs[0] = '{8'h04, 1'b0, 4'b1111};
    vecs[1] = '{8'h07, 1'b1, 4'b1111};
    vecs[2] = '{8'h02, 1'b1, 4'b1111};
    vecs[3] = '{8'h04, 1'b1, 4'b1101};
    vecs[4] = '{8'h05, 1'b0, 4'b1101};
    vecs[5] = '{8'h05, 1'b1, 4'b1001};
    vecs[6] = '{8'h03, 1'b1, 4'b1000};
    vecs[7] = '{8'hFF, 1'b1, 4'b1000};
    vecs[8] = '{8'h06, 1'b1, 4'b0000};

    reset           = 1'b0;
    btn_aumenta     = 1'b0;
    btn_disminuye   = 1'b0;
    btn_siguiente   = 1'b0;
    btn_anterior    = 1'b0;
    bus.Port_ID     = 8'h00;
    bus.Read_Strobe = 1'b0;

    #2 check("reset_async", fl, 4'b0000);
    ciclos(3);
    check("reset_sostenido", fl, 4'b0000);
    reset = 1'b1;
    ciclos(2);

    // Clean press: flag appears exactly 7 cycles after the raw edge.
    btn_aumenta = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      ciclos(1);
      check($sformatf("limpio_k%0d", k), fl, (k >= 7) ? 4'b0001 : 4'b0000);
    end
    btn_aumenta = 1'b0;
    ciclos(10);
    leer(PORT_AUMENTA);
    check("limpio_borrado", fl, 4'b0000);

    // Bounce: two cycles high / two low, then a final steady rise.
    subidas = 0;
    prev    = fl[1];
    for (int c = 0; c < 12; c++) begin
      btn_disminuye = ((c / 2) % 2 == 0);
      ciclos(1);
      check($sformatf("rebote_c%0d", c), fl, 4'b0000);
      if (fl[1] && !prev) subidas++;
      prev = fl[1];
    end
    btn_disminuye = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      ciclos(1);
      check($sformatf("rebote_k%0d", k), fl, (k >= 7) ? 4'b0010 : 4'b0000);
      if (fl[1] && !prev) subidas++;
      prev = fl[1];
    end
    check_cnt("rebote_una_vez", subidas, 1);
    btn_disminuye = 1'b0;
    ciclos(10);
    leer(PORT_DISMINUYE);

    // All four keys pressed together, then the read-clear decode table.
    btn_aumenta   = 1'b1;
    btn_disminuye = 1'b1;
    btn_siguiente = 1'b1;
    btn_anterior  = 1'b1;
    ciclos(6);
    check("todos_antes", fl, 4'b0000);
    ciclos(1);
    check("todos_juntos", fl, 4'b1111);

    for (int i = 0; i < 9; i++) begin
      bus.Port_ID     = vecs[i].port_id;
      bus.Read_Strobe = vecs[i].strobe;
      ciclos(1);
      bus.Read_Strobe = 1'b0;
      bus.Port_ID     = 8'h00;
      check($sformatf("lectura_%0d_p%0h_s%0b", i, vecs[i].port_id, vecs[i].strobe),
            fl, vecs[i].flags_exp);
    end

    btn_aumenta   = 1'b0;
    btn_disminuye = 1'b0;
    btn_siguiente = 1'b0;
    btn_anterior  = 1'b0;
    ciclos(10);
    check("sin_autorepeticion", fl, 4'b0000);

    // Collision: clear of anterior in the same cycle as its press event.
    btn_anterior = 1'b1;
    ciclos(6);
    check("colision_antes", fl, 4'b0000);
    bus.Port_ID     = PORT_ANTERIOR;
    bus.Read_Strobe = 1'b1;
    ciclos(1);
    bus.Read_Strobe = 1'b0;
    bus.Port_ID     = 8'h00;
    check("colision", fl, 4'b1000);
    ciclos(1);
    check("colision_mantiene", fl, 4'b1000);
    btn_anterior = 1'b0;
    ciclos(10);

    // Reset while aumenta is in CONFIRMA_PULSO with count 2.
    btn_aumenta = 1'b1;
    ciclos(5);
    reset = 1'b0;
    #1 check("reset_inmediato", fl, 4'b0000);
    ciclos(1);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      ciclos(1);
      check($sformatf("post_reset_k%0d", k), fl, (k >= 7) ? 4'b0001 : 4'b0000);
    end

    // Repeat: clear, release, press again gives a second set.
    leer(PORT_AUMENTA);
    check("repeticion_borrado", fl, 4'b0000);
    btn_aumenta = 1'b0;
    ciclos(10);
    check("repeticion_suelto", fl, 4'b0000);
    btn_aumenta = 1'b1;
    ciclos(6);
    check("repeticion_antes", fl, 4'b0000);
    ciclos(1);
    check("repeticion_segunda", fl, 4'b0001);

    leer(PORT_AUMENTA);
    btn_aumenta = 1'b0;
    ciclos(10);

    // Long hold read-cleared at cycle 10 must not set again.
    btn_aumenta = 1'b1;
    unos = 0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 10) begin
        bus.Port_ID     = PORT_AUMENTA;
        bus.Read_Strobe = 1'b1;
      end
      ciclos(1);
      bus.Read_Strobe = 1'b0;
      bus.Port_ID     = 8'h00;
      if (fl[0]) unos++;
    end
    check_cnt("retencion_larga_ciclos", unos, 3);
    check("retencion_larga_final", fl, 4'b0000);
    btn_aumenta = 1'b0;
    ciclos(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/antirrebote_teclado.md
ANTIRREBOTE_TECLADO -- requirements
Module: antirrebote_teclado

Interface
REQ-001 SHALL have parameter CNT_MAX, default 500000, stable-input cycles needed to accept a press or release (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 19, debounce counter width, with 2^CNT_W >= CNT_MAX.
REQ-003 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset: state clears immediately while reset=0.
REQ-005 SHALL have ports btn_aumenta, btn_disminuye, btn_siguiente, btn_anterior, input, 1 each, raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port Port_ID, input, 8, PicoBlaze port address.
REQ-007 SHALL have port Read_Strobe, input, 1, PicoBlaze read strobe, one cycle per INPUT instruction.
REQ-008 SHALL have ports aumenta, disminuye, siguiente, anterior, output, 1 each, registered "press pending" flags for the keyboard register stage.

Function
REQ-009 SHALL pass each raw button through its own 2-flop synchronizer before any other logic.
REQ-010 SHALL debounce each button with an independent FSM with states REPOSO, CONFIRMA_PULSO, PULSADO and CONFIRMA_SUELTA, plus a CNT_W-bit counter.
REQ-011 REPOSO SHALL go to CONFIRMA_PULSO with counter=0 when synced input=1, and otherwise stay in REPOSO.
REQ-012 CONFIRMA_PULSO SHALL increment the counter each cycle while synced input=1, return to REPOSO if input=0, and at counter=CNT_MAX-1 go to PULSADO and emit a one-cycle internal press event.
REQ-013 PULSADO SHALL go to CONFIRMA_SUELTA with counter=0 when synced input=0; it emits no further events while held, so there is no auto-repeat.
REQ-014 CONFIRMA_SUELTA SHALL return to PULSADO if input=1, and at counter=CNT_MAX-1 go to REPOSO.
REQ-015 A press event SHALL set the matching output flag on the next edge: latency from raw rising edge to flag=1 is 2+CNT_MAX+1 cycles for a clean input.
REQ-016 A flag SHALL clear on the edge after Read_Strobe=1 with Port_ID equal to its port: 8'h03 aumenta, 8'h04 disminuye, 8'h05 siguiente, 8'h06 anterior.
REQ-017 Read_Strobe with any other Port_ID, or Port_ID match without Read_Strobe, SHALL leave flags unchanged.
REQ-018 When set and clear hit the same flag in the same cycle, set SHALL win and the flag ends at 1, so no press is lost.
REQ-019 A press event while the flag is already 1 SHALL keep it at 1; events do not count or queue.
REQ-020 The four buttons SHALL be fully independent; simultaneous presses set all affected flags in the same cycle.
REQ-021 The counter SHALL never exceed CNT_MAX-1, and SHALL clear on every state change.

Reset
REQ-022 While reset=0, all synchronizers, counters and flags SHALL be 0, all FSMs SHALL be in REPOSO, and all outputs SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-debounce SHALL discard partial counts; a button held through reset release SHALL need a full 2+CNT_MAX+1 cycles before its flag sets.

Structure
REQ-024 Port ID constants (8'h03..8'h06), CNT_MAX default and FSM state encoding SHALL live in a shared package, also used by the keyboard register stage.
REQ-025 The synchronizer, FSM and counter for one button SHALL be a sub-module antirrebote_boton (outputs: press event pulse), instantiated four times; the top holds the four flags and the read-clear decode.

Verification (CNT_MAX=4, CNT_W=3)
REQ-026 Clean press: btn_aumenta 0->1 held 20 cycles -> aumenta=1 exactly 7 cycles after the edge; holds 1; other flags 0.
REQ-027 Bounce: btn_disminuye toggles every 2 cycles for 12 cycles, then holds 1 -> no set during bouncing; disminuye sets exactly once, 7 cycles after the final rise.
REQ-028 Read-clear: siguiente=1; Read_Strobe=1 with Port_ID=8'h04 -> siguiente stays 1; then with Port_ID=8'h05 -> siguiente=0 next cycle.
REQ-029 Collision: Read_Strobe=1 with Port_ID=8'h06 in the same cycle as the anterior press event -> anterior=1 afterwards.
REQ-030 Reset mid-operation: reset=0 for 1 cycle while btn_aumenta is in CONFIRMA_PULSO with count 2, button kept high -> outputs 0 at once; aumenta sets 7 cycles after reset release.
REQ-031 Repeat: press, read-clear, release for 10 cycles, press again -> two separate sets. One 50-cycle hold, read-cleared at cycle 10 -> no second set.
